tank_ctrl: RTL and testbench

Parametrised player-tank controller for the battle-tanks core: turns the one-hot `player` keypad code into direction, bounded motion, collision back-off, fire requests and an explosion/respawn cycle. Sits between the per-player input decoder and the VGA sprite/bullet/collision logic. It is the successor to the fixed-speed tank mover, adding configurable speed and step, arena clamping, a respawn delay with a 4-phase explosion handshake, and fire with cooldown.

---
 rtl/tank_ctrl.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_tank_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tank_ctrl.sv
// -----------------------------------------------------------------------------
// tank_ctrl -- player tank controller for the battle-tanks core.
//
// Turns the one-hot keypad code into a facing direction and bounded motion.
// Moves are clamped to the arena, and a blocked tank backs off to its last
// position. Bullet hits are handled with an explosion/ack handshake and a
// respawn delay. Motion, respawn and cooldown all advance on a free-running
// tick derived from clk25.
//
// Optional feature macro: TANK_FIRE_EN
//   defined   -> FIRE key (player[4]) issues one-cycle fire pulses with a
//                tick-based cooldown.
//   undefined -> fire is tied low; the port is kept.
//
// Ports:
//   clk25          in   25 MHz pixel clock (sole clock)
//   reset          in   asynchronous active-low reset
//   xpos / ypos    in   spawn coordinates, sampled in SPAWN
//   player         in   keypad code: DOWN=0001 RIGHT=0010 UP=0100 LEFT=1000,
//                       bit 4 = FIRE
//   blocked        in   tank overlaps a wall/tank at its current position
//   explosion_flag in   hit request from the bullet logic
//   x_tank/y_tank  out  tank position (top-left corner)
//   direction      out  UP=00 DOWN=01 LEFT=10 RIGHT=11
//   alive          out  high only while in ALIVE
//   moving         out  high when the last tick changed the position
//   explosion_ack  out  explosion handshake acknowledge
//   fire           out  one-cycle shot request
// -----------------------------------------------------------------------------
module tank_ctrl #(
    parameter int TICK_DIV      = 200000,
    parameter int STEP          = 1,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 608,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 448,
    parameter int RESPAWN_TICKS = 64,
    parameter int FIRE_COOLDOWN = 50
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [9:0] xpos,
    input  logic [8:0] ypos,
    input  logic [4:0] player,
    input  logic       blocked,
    input  logic       explosion_flag,
    output logic [9:0] x_tank,
    output logic [8:0] y_tank,
    output logic [1:0] direction,
    output logic       alive,
    output logic       moving,
    output logic       explosion_ack,
    output logic       fire
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int RSP_W = $clog2(RESPAWN_TICKS + 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'b00,
        ST_ALIVE = 2'b01,
        ST_DEAD  = 2'b10
    } state_t;

    state_t           state_r, state_n;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [9:0]       x_r, x_n, sx_r, sx_n;
    logic [8:0]       y_r, y_n, sy_r, sy_n;
    logic [1:0]       dir_r, dir_n;
    logic             alive_r, moving_r, moving_n, ack_r, ack_n;
    logic [RSP_W-1:0] rsp_r, rsp_n;
    logic             key_one_hot_s;

    // Moves are computed 12 bits wide and signed so x+STEP (up to 1038)
    // and 0-STEP are representable before clamping -- nothing ever wraps.
    logic signed [11:0] x_ext_s, y_ext_s, step_s;

    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v == 4'b0001) || (v == 4'b0010) ||
               (v == 4'b0100) || (v == 4'b1000);
    endfunction

    function automatic logic [1:0] key_to_dir(input logic [3:0] v);
        logic [1:0] d;
        case (v)
            4'b0001: d = DIR_DOWN;
            4'b0010: d = DIR_RIGHT;
            4'b0100: d = DIR_UP;
            4'b1000: d = DIR_LEFT;
            default: d = DIR_UP;
        endcase
        return d;
    endfunction

    function automatic logic [9:0] clamp_x(input logic signed [11:0] v);
        logic [9:0] r;
        if (v > $signed(12'(X_MAX))) begin
            r = 10'(X_MAX);
        end else if (v < $signed(12'(X_MIN))) begin
            r = 10'(X_MIN);
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

    function automatic logic [8:0] clamp_y(input logic signed [11:0] v);
        logic [8:0] r;
        if (v > $signed(12'(Y_MAX))) begin
            r = 9'(Y_MAX);
        end else if (v < $signed(12'(Y_MIN))) begin
            r = 9'(Y_MIN);
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

    assign tick_s        = (div_r == DIV_W'(TICK_DIV - 1));
    assign key_one_hot_s = is_one_hot4(player[3:0]);
    assign x_ext_s       = $signed({2'b00, x_r});
    assign y_ext_s       = $signed({3'b000, y_r});
    assign step_s        = $signed(12'(STEP));

    // Free-running motion tick divider, independent of the FSM.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Next-state and next-output logic for the SPAWN/ALIVE/DEAD FSM.
    always_comb begin
        state_n  = state_r;
        x_n      = x_r;
        y_n      = y_r;
        sx_n     = sx_r;
        sy_n     = sy_r;
        dir_n    = dir_r;
        moving_n = moving_r;
        ack_n    = ack_r;
        rsp_n    = rsp_r;
        case (state_r)
            ST_SPAWN: begin
                x_n      = xpos;
                y_n      = ypos;
                // The saved position starts at the spawn point so an early
                // blocked tick cannot restore a stale previous-life position.
                sx_n     = xpos;
                sy_n     = ypos;
                dir_n    = DIR_UP;
                moving_n = 1'b0;
                ack_n    = 1'b0;
                state_n  = ST_ALIVE;
            end
            ST_ALIVE: begin
                if (key_one_hot_s) begin
                    dir_n = key_to_dir(player[3:0]);
                end else begin
                    dir_n = dir_r;
                end
                if (explosion_flag) begin
                    state_n  = ST_DEAD;
                    ack_n    = 1'b1;
                    rsp_n    = RSP_W'(RESPAWN_TICKS);
                    moving_n = 1'b0;
                end else if (tick_s && blocked) begin
                    x_n      = sx_r;
                    y_n      = sy_r;
                    moving_n = 1'b0;
                end else if (tick_s && key_one_hot_s) begin
                    sx_n = x_r;
                    sy_n = y_r;
                    case (player[3:0])
                        4'b0001: y_n = clamp_y(y_ext_s + step_s);
                        4'b0010: x_n = clamp_x(x_ext_s + step_s);
                        4'b0100: y_n = clamp_y(y_ext_s - step_s);
                        4'b1000: x_n = clamp_x(x_ext_s - step_s);
                        default: x_n = x_r;
                    endcase
                    moving_n = (x_n != x_r) || (y_n != y_r);
                end else if (tick_s) begin
                    moving_n = 1'b0;
                end else begin
                    moving_n = moving_r;
                end
            end
            ST_DEAD: begin
                if (tick_s && (rsp_r != '0)) begin
                    rsp_n = rsp_r - RSP_W'(1);
                end else begin
                    rsp_n = rsp_r;
                end
                if (!explosion_flag) begin
                    ack_n = 1'b0;
                end else begin
                    ack_n = ack_r;
                end
                // Leave only once the delay has run out and the bullet logic
                // has seen the ack drop (four-phase handshake complete).
                if ((rsp_r == '0) && !explosion_flag && !ack_r) begin
                    state_n = ST_SPAWN;
                end else begin
                    state_n = ST_DEAD;
                end
            end
            default: begin
                state_n = ST_SPAWN;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_SPAWN;
            x_r      <= 10'd0;
            y_r      <= 9'd0;
            sx_r     <= 10'd0;
            sy_r     <= 9'd0;
            dir_r    <= DIR_UP;
            alive_r  <= 1'b0;
            moving_r <= 1'b0;
            ack_r    <= 1'b0;
            rsp_r    <= '0;
        end else begin
            state_r  <= state_n;
            x_r      <= x_n;
            y_r      <= y_n;
            sx_r     <= sx_n;
            sy_r     <= sy_n;
            dir_r    <= dir_n;
            alive_r  <= (state_n == ST_ALIVE);
            moving_r <= moving_n;
            ack_r    <= ack_n;
            rsp_r    <= rsp_n;
        end
    end

`ifdef TANK_FIRE_EN
    localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);

    logic [CD_W-1:0] cd_r, cd_n;
    logic            fire_r, fire_n;

    // Fire request and cooldown; a shot takes priority over the tick decrement.
    always_comb begin
        fire_n = 1'b0;
        cd_n   = cd_r;
        if (state_r == ST_SPAWN) begin
            cd_n = '0;
        end else if ((state_r == ST_ALIVE) && !explosion_flag &&
                     player[4] && (cd_r == '0)) begin
            fire_n = 1'b1;
            cd_n   = CD_W'(FIRE_COOLDOWN);
        end else if (tick_s && (cd_r != '0)) begin
            cd_n = cd_r - CD_W'(1);
        end else begin
            cd_n = cd_r;
        end
    end

    // Fire pulse and cooldown registers.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            cd_r   <= '0;
            fire_r <= 1'b0;
        end else begin
            cd_r   <= cd_n;
            fire_r <= fire_n;
        end
    end

    assign fire = fire_r;
`else
    logic fire_key_unused_s;

    assign fire_key_unused_s = player[4];
    assign fire              = 1'b0;
`endif

    assign x_tank        = x_r;
    assign y_tank        = y_r;
    assign direction     = dir_r;
    assign alive         = alive_r;
    assign moving        = moving_r;
    assign explosion_ack = ack_r;

endmodule

// File: tb/tb_tank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tank_ctrl -- directed self-checking bench for tank_ctrl.
// Small parameters (TICK_DIV=4, STEP=2, X_MAX=107, Y_MIN=197,
// RESPAWN_TICKS=3, FIRE_COOLDOWN=2) keep every scenario a few ticks long.
// The divider restarts at reset, so the edge with index k (counted from
// reset release) is a tick edge when k%4==3; e counts the edges taken.
// -----------------------------------------------------------------------------
module tb_tank_ctrl;

`ifdef TANK_FIRE_EN
    localparam bit FIRE_ON = 1'b1;
`else
    localparam bit FIRE_ON = 1'b0;
`endif

    logic       clk25;
    logic       reset;
    logic [9:0] xpos;
    logic [8:0] ypos;
    logic [4:0] player;
    logic       blocked;
    logic       explosion_flag;
    logic [9:0] x_tank;
    logic [8:0] y_tank;
    logic [1:0] direction;
    logic       alive;
    logic       moving;
    logic       explosion_ack;
    logic       fire;

    int n_cmp;
    int n_bad;
    int e;

    tank_ctrl #(
        .TICK_DIV      (4),
        .STEP          (2),
        .X_MIN         (0),
        .X_MAX         (107),
        .Y_MIN         (197),
        .Y_MAX         (448),
        .RESPAWN_TICKS (3),
        .FIRE_COOLDOWN (2)
    ) dut (
        .clk25          (clk25),
        .reset          (reset),
        .xpos           (xpos),
        .ypos           (ypos),
        .player         (player),
        .blocked        (blocked),
        .explosion_flag (explosion_flag),
        .x_tank         (x_tank),
        .y_tank         (y_tank),
        .direction      (direction),
        .alive          (alive),
        .moving         (moving),
        .explosion_ack  (explosion_ack),
        .fire           (fire)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
        e++;
    endtask

    // Advance until the edge just taken was a tick edge.
    task automatic to_tick();
        do step(); while (e % 4 != 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        e = 0;
        reset = 1'b0;
        xpos = 10'd100;
        ypos = 9'd200;
        player = 5'b00000;
        blocked = 1'b0;
        explosion_flag = 1'b0;

        // Reset values.
        #5;
        check("rst_x", 32'(x_tank), 32'd0);
        check("rst_y", 32'(y_tank), 32'd0);
        check("rst_dir", 32'(direction), 32'd0);
        check("rst_alive", 32'(alive), 32'd0);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_ack", 32'(explosion_ack), 32'd0);
        check("rst_fire", 32'(fire), 32'd0);

        @(negedge clk25);
        reset = 1'b1;

        // SPAWN edge -> ALIVE at the spawn point.
        step();
        check("spawn_x", 32'(x_tank), 32'd100);
        check("spawn_y", 32'(y_tank), 32'd200);
        check("spawn_dir", 32'(direction), 32'd0);
        check("spawn_alive", 32'(alive), 32'd1);

        // RIGHT: direction one cycle later, position on ticks.
        player = 5'b00010;
        step();
        check("dir_right", 32'(direction), 32'd3);
        check("x_before_tick", 32'(x_tank), 32'd100);
        to_tick();
        check("x_tick1", 32'(x_tank), 32'd102);
        check("moving_tick1", 32'(moving), 32'd1);
        to_tick();
        to_tick();
        check("x_tick3", 32'(x_tank), 32'd106);
        check("moving_tick3", 32'(moving), 32'd1);

        // Multi-hot: no move, direction held.
        player = 5'b01010;
        to_tick();
        check("multihot_x", 32'(x_tank), 32'd106);
        check("multihot_moving", 32'(moving), 32'd0);
        check("multihot_dir", 32'(direction), 32'd3);

        // Clamp at X_MAX (106+2 -> 107), then hold.
        player = 5'b00010;
        to_tick();
        check("xmax_clamp", 32'(x_tank), 32'd107);
        check("xmax_moving", 32'(moving), 32'd1);
        to_tick();
        check("xmax_hold", 32'(x_tank), 32'd107);
        check("xmax_hold_moving", 32'(moving), 32'd0);

        // UP then blocked back-off to the saved position.
        player = 5'b00100;
        step();
        check("dir_up", 32'(direction), 32'd0);
        to_tick();
        check("y_up", 32'(y_tank), 32'd198);
        blocked = 1'b1;
        to_tick();
        check("blocked_y", 32'(y_tank), 32'd200);
        check("blocked_x", 32'(x_tank), 32'd107);
        check("blocked_moving", 32'(moving), 32'd0);
        blocked = 1'b0;
        to_tick();
        check("resume_y", 32'(y_tank), 32'd198);
        to_tick();
        check("ymin_clamp", 32'(y_tank), 32'd197);
        check("ymin_moving", 32'(moving), 32'd1);
        to_tick();
        check("ymin_nowrap", 32'(y_tank), 32'd197);
        check("ymin_hold_moving", 32'(moving), 32'd0);

        // LEFT move, saved position becomes (107,197).
        player = 5'b01000;
        step();
        check("dir_left", 32'(direction), 32'd2);
        to_tick();
        check("x_left", 32'(x_tank), 32'd105);

        // Explosion on the same tick as blocked: explosion wins.
        step();
        step();
        step();
        explosion_flag = 1'b1;
        blocked = 1'b1;
        step();
        check("expl_x", 32'(x_tank), 32'd105);
        check("expl_y", 32'(y_tank), 32'd197);
        check("expl_ack", 32'(explosion_ack), 32'd1);
        check("expl_alive", 32'(alive), 32'd0);
        check("expl_moving", 32'(moving), 32'd0);
        blocked = 1'b0;
        player = 5'b00010;
        for (int i = 0; i < 9; i++) step();
        check("dead_ack_held", 32'(explosion_ack), 32'd1);
        check("dead_dir_held", 32'(direction), 32'd2);
        check("dead_x_held", 32'(x_tank), 32'd105);

        // Flag released: ack drops next cycle, respawn after the delay.
        explosion_flag = 1'b0;
        step();
        check("ack_release", 32'(explosion_ack), 32'd0);
        check("dead_alive", 32'(alive), 32'd0);
        player = 5'b00000;
        xpos = 10'd50;
        ypos = 9'd60;
        step();
        step();
        step();
        check("respawn_wait_alive", 32'(alive), 32'd0);
        check("respawn_wait_x", 32'(x_tank), 32'd105);
        step();
        check("respawn_alive", 32'(alive), 32'd1);
        check("respawn_x", 32'(x_tank), 32'd50);
        check("respawn_y", 32'(y_tank), 32'd60);
        check("respawn_dir", 32'(direction), 32'd0);
        check("respawn_moving", 32'(moving), 32'd0);

        // FIRE held: pulses at edges 66 and 72 with the feature, never without.
        player = 5'b10000;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fire", 32'(fire), 32'(FIRE_ON && ((e == 67) || (e == 73))));
        end

        // Reset in the middle of operation.
        reset = 1'b0;
        #1;
        check("midrst_x", 32'(x_tank), 32'd0);
        check("midrst_y", 32'(y_tank), 32'd0);
        check("midrst_alive", 32'(alive), 32'd0);
        check("midrst_fire", 32'(fire), 32'd0);
        player = 5'b00000;
        @(negedge clk25);
        reset = 1'b1;
        e = 0;
        step();
        check("rerespawn_x", 32'(x_tank), 32'd50);
        check("rerespawn_alive", 32'(alive), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
